dpe_accum: RTL
==============

Name: dpe_accum

Overview:
- Sits directly downstream of the dot-product engine and consumes its valid/result stream.
- Accumulates cfg_len consecutive partial dot products into one full dot product.
- Requantizes each full sum to OPREC bits: rounding arithmetic shift, optional ReLU, then saturation.
- Buffers requantized outputs in a small FIFO with a valid/ready handshake toward the next layer stage.

Parameters:
- DATAW, 32, width of signed partial result from the dot-product engine
- ACCW, 48, accumulator width; must be >= DATAW+LEN_W (elaboration-time check)
- LEN_W, 8, width of cfg_len
- SHW, 5, width of cfg_shift
- OPREC, 8, width of signed requantized output
- FIFO_DEPTH, 4, output FIFO entries (power of two, >= 2)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- cfg_len  in  LEN_W  partials per dot product (0 treated as 1)
- cfg_shift  in  SHW  right-shift amount for requantization
- cfg_relu  in  1  1 = clamp negative sums to 0
- i_valid  in  1  partial result valid (no backpressure possible)
- i_result  in  DATAW  signed partial dot product
- o_valid  out  1  FIFO head valid
- o_ready  in  1  downstream accepts head
- o_data  out  OPREC  signed requantized output
- o_ovf  out  1  sticky: a completed result was dropped

Behaviour:
- Reset (rst=0, asynchronous): cnt=0, acc=0, requant stage invalid, FIFO empty, o_valid=0, o_data=0, o_ovf=0.
- Config capture: cfg_len/cfg_shift/cfg_relu latched on the accepted i_valid when cnt==0; held for the whole dot product. Changes mid-accumulation are ignored.
- Accumulate, on each i_valid:
  - sign-extend i_result to ACCW;
  - if cnt==0: acc=ext;
  - else acc=acc+ext;
  - cnt increments.
  - Cycles without i_valid hold state.
- Completion: on the i_valid where cnt==len_l-1 (len_l = latched length, min 1):
  - sum = acc+ext (or ext if len_l==1) is registered into the requant stage at the next edge;
  - cnt returns to 0, so a new dot product may start on the very next cycle with no bubble.
- Requant, combinational from the requant register:
  - if shift>0: r = (sum + (1<<(shift-1))) >>> shift (round half up); else r = sum.
  - if relu and r<0: r=0.
  - saturate to [-(2^(OPREC-1)), 2^(OPREC-1)-1].
- FIFO write: the requant result is written at the edge after the requant register loads.
- Latency: final i_valid in cycle T gives requant valid in T+1 and o_valid=1 in T+2 when the FIFO was empty.
- Handshake:
  - pop when o_valid && o_ready;
  - o_data is the FIFO head and stays stable while o_valid && !o_ready;
  - o_data holds its last value when empty.
- Full FIFO:
  - write while full with simultaneous pop: accepted, occupancy unchanged.
  - write while full without pop: entry dropped, o_ovf=1 (sticky until reset), FIFO contents unchanged.
- Empty FIFO: o_ready is ignored.
- Pointers: wrap modulo FIFO_DEPTH; full/empty are distinguished with an extra pointer bit.
- Reset mid-accumulation or mid-FIFO discards all partial and queued data.

Decomposition:
- Shared package dpe_pkg:
  - localparams for default DATAW/OPREC;
  - function sat_round(sum, shift, relu) returning OPREC bits, shared with other requant points.
- One sub-module, dpe_ofifo: sync FIFO with parameters WIDTH and DEPTH, ports push/pop/full/empty/head, asynchronous active-low reset.
- Counter, accumulator and requant register stay in dpe_accum.

Test Plan:
- len=4, shift=0, relu=0; inputs 30,40,50,-20 back-to-back; o_ready=1 -> o_data=100 at T+2, single o_valid pulse.
- len=2, shift=2; inputs 5,1 -> 2. Inputs -7,0 with shift=1 -> -3 (round half up).
- Saturation and ReLU, len=1:
  - relu=0: input 1000 -> 127; input -1000 -> -128.
  - relu=1: input -50 -> 0; input 1000 -> 127.
- Backpressure:
  - o_ready=0, len=1, shift=0; inputs 1..5 -> 4 entries held, o_ovf=1, 5 dropped.
  - then o_ready=1 -> outputs 1,2,3,4 in order; o_ovf stays 1.
- Full plus simultaneous pop: FIFO full; o_ready=1 in the same cycle a new result writes -> no drop, o_ovf=0, order preserved.
- Config and reset:
  - len=3; change cfg_len to 1 after the first partial -> still 3 partials summed.
  - assert rst after 2 of 3 partials, then release and feed 7 with len=1 -> output 7, no stale sum, o_valid=0 during reset.

Source files
------------

// File: rtl/dpe_pkg.sv
// Shared definitions for the dot-product engine datapath: default widths and
// the common round/ReLU/saturate requantization helper.
package dpe_pkg;

    localparam int unsigned DATAW_DEF = 32;
    localparam int unsigned ACCW_DEF  = 48;
    localparam int unsigned OPREC_DEF = 8;
    localparam int unsigned SUM_W     = 64;

    // The sum is widened to SUM_W so that the rounding increment cannot overflow.
    // The caller truncates the result to its own output precision.
    function automatic logic signed [SUM_W-1:0] sat_round(
        input logic signed [SUM_W-1:0] sum,
        input int unsigned             shift,
        input logic                    relu,
        input int unsigned             prec = OPREC_DEF
    );
        logic signed [SUM_W-1:0] r;
        logic signed [SUM_W-1:0] hi;
        logic signed [SUM_W-1:0] lo;
        r = sum;
        if (shift != 0) begin
            r = (sum + (64'sd1 <<< (shift - 1))) >>> shift;
        end
        if (relu && r[SUM_W-1]) begin
            r = '0;
        end
        hi = (64'sd1 <<< (prec - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (prec - 1));
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/dpe_ofifo.sv
// Synchronous output FIFO with extra-bit pointers; the head holds its last
// popped value while empty.
module dpe_ofifo
    import dpe_pkg::*;
#(
    parameter int unsigned WIDTH = OPREC_DEF,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] last_q;
    logic             pop_en;
    logic             push_en;

    always_comb begin
        empty_o = (wr_q == rd_q);
        full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        pop_en  = pop_i && !empty_o;
        // A full FIFO still accepts a write when the head leaves in the same cycle.
        push_en = push_i && (!full_o || pop_en);
        head_o  = empty_o ? last_q : mem_q[rd_q[AW-1:0]];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q   <= '0;
            rd_q   <= '0;
            last_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_en) begin
                mem_q[wr_q[AW-1:0]] <= data_i;
                wr_q                <= wr_q + 1'b1;
            end
            if (pop_en) begin
                rd_q   <= rd_q + 1'b1;
                last_q <= mem_q[rd_q[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/dpe_accum.sv
// Accumulates cfg_len partial dot products, requantizes the full sum and
// queues it in a small output FIFO with a valid/ready handshake.
module dpe_accum
    import dpe_pkg::*;
#(
    parameter int unsigned DATAW      = DATAW_DEF,
    parameter int unsigned ACCW       = ACCW_DEF,
    parameter int unsigned LEN_W      = 8,
    parameter int unsigned SHW        = 5,
    parameter int unsigned OPREC      = OPREC_DEF,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [SHW-1:0]   cfg_shift,
    input  logic             cfg_relu,
    input  logic             i_valid,
    input  logic [DATAW-1:0] i_result,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [OPREC-1:0] o_data,
    output logic             o_ovf
);

    if (ACCW < DATAW + LEN_W) begin : g_accw_chk
        $error("dpe_accum: ACCW must be >= DATAW + LEN_W");
    end
    if (ACCW >= SUM_W) begin : g_sumw_chk
        $error("dpe_accum: ACCW must be narrower than the requant helper width");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
        $error("dpe_accum: FIFO_DEPTH must be a power of two >= 2");
    end

    logic [LEN_W-1:0]        cnt_q, cnt_d;
    logic signed [ACCW-1:0]  acc_q, acc_d;
    logic [LEN_W-1:0]        len_q;
    logic [SHW-1:0]          shift_q;
    logic                    relu_q;

    logic                    rq_valid_q;
    logic signed [ACCW-1:0]  rq_sum_q;
    logic [SHW-1:0]          rq_shift_q;
    logic                    rq_relu_q;
    logic                    ovf_q;

    logic                    first;
    logic                    last;
    logic [LEN_W-1:0]        len_cur;
    logic [LEN_W-1:0]        len_eff;
    logic [SHW-1:0]          shift_cur;
    logic                    relu_cur;
    logic signed [ACCW-1:0]  ext;
    logic signed [ACCW-1:0]  sum_d;
    logic [OPREC-1:0]        rq_data;
    logic                    fifo_full;
    logic                    fifo_empty;

    // Configuration is taken live from the ports on the first partial and from
    // the latched copy afterwards, so the first partial already obeys it.
    always_comb begin
        first     = (cnt_q == '0);
        len_cur   = first ? cfg_len   : len_q;
        shift_cur = first ? cfg_shift : shift_q;
        relu_cur  = first ? cfg_relu  : relu_q;
        len_eff   = (len_cur == '0) ? LEN_W'(1) : len_cur;
        ext       = {{(ACCW-DATAW){i_result[DATAW-1]}}, i_result};
        sum_d     = first ? ext : acc_q + ext;
        last      = (cnt_q == len_eff - LEN_W'(1));
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        if (i_valid) begin
            acc_d = sum_d;
            cnt_d = last ? '0 : cnt_q + LEN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            len_q      <= '0;
            shift_q    <= '0;
            relu_q     <= 1'b0;
            rq_valid_q <= 1'b0;
            rq_sum_q   <= '0;
            rq_shift_q <= '0;
            rq_relu_q  <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            rq_valid_q <= i_valid && last;
            if (i_valid && first) begin
                len_q   <= cfg_len;
                shift_q <= cfg_shift;
                relu_q  <= cfg_relu;
            end
            // The requant stage carries its own config so the next dot product
            // may latch new settings while this sum is still being written.
            if (i_valid && last) begin
                rq_sum_q   <= sum_d;
                rq_shift_q <= shift_cur;
                rq_relu_q  <= relu_cur;
            end
            if (rq_valid_q && fifo_full && !o_ready) begin
                ovf_q <= 1'b1;
            end
        end
    end

    always_comb begin
        rq_data = OPREC'(sat_round(SUM_W'(rq_sum_q), 32'(rq_shift_q), rq_relu_q, OPREC));
    end

    dpe_ofifo #(
        .WIDTH (OPREC),
        .DEPTH (FIFO_DEPTH)
    ) u_ofifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (rq_valid_q),
        .data_i  (rq_data),
        .pop_i   (o_ready),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (o_data)
    );

    assign o_valid = !fifo_empty;
    assign o_ovf   = ovf_q;

endmodule
